// File: rtl/vga_pkg.sv
// Shared 1024x768@60 timing constants and the timing bus that the draw pipeline
// carries alongside its own data.
package vga_pkg;

    localparam int VGA_CNT_W = 11;

    localparam int XGA_H_VIS  = 1024;
    localparam int XGA_H_FP   = 24;
    localparam int XGA_H_SYNC = 136;
    localparam int XGA_H_BP   = 160;
    localparam int XGA_V_VIS  = 768;
    localparam int XGA_V_FP   = 3;
    localparam int XGA_V_SYNC = 6;
    localparam int XGA_V_BP   = 29;

    localparam int H_TOT    = XGA_H_VIS + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
    localparam int V_TOT    = XGA_V_VIS + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
    localparam int HS_START = XGA_H_VIS + XGA_H_FP;
    localparam int HS_END   = HS_START + XGA_H_SYNC;
    localparam int VS_START = XGA_V_VIS + XGA_V_FP;
    localparam int VS_END   = VS_START + XGA_V_SYNC;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
    } vga_timing_t;

endpackage

// File: rtl/tg_axis_counter.sv
// One timing axis: wrapping position counter with blank and sync flags that are
// registered from the next count, so flags and count always describe the same pixel.
module tg_axis_counter
    import vga_pkg::*;
#(
    parameter int   CNT_W      = VGA_CNT_W,
    parameter int   TOTAL      = H_TOT,
    parameter int   SYNC_START = HS_START,
    parameter int   SYNC_END   = HS_END,
    parameter int   VIS        = XGA_H_VIS,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             sync,
    output logic             wrap
);

    if (TOTAL > (1 << CNT_W)) begin : g_total_too_wide
        $error("tg_axis_counter: TOTAL does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_C   = CNT_W'(VIS);
    localparam logic [CNT_W-1:0] SSTRT_C = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SEND_C  = CNT_W'(SYNC_END);

    logic [CNT_W-1:0] count_q, count_d;
    logic             blank_q, blank_d;
    logic             sync_q, sync_d;

    // wrap is combinational so the next axis can advance on the same edge
    assign wrap = en && (count_q == LAST_C);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST_C) ? '0 : count_q + CNT_W'(1);
        end
        blank_d = (count_d >= VIS_C);
        sync_d  = ((count_d >= SSTRT_C) && (count_d < SEND_C)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blank = blank_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: pixel coordinates, sync, blanking, line/frame
// strobes and a completed-frame counter, all registered on the same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS    = XGA_H_VIS,
    parameter int   H_FP     = XGA_H_FP,
    parameter int   H_SYNC   = XGA_H_SYNC,
    parameter int   H_BP     = XGA_H_BP,
    parameter int   V_VIS    = XGA_V_VIS,
    parameter int   V_FP     = XGA_V_FP,
    parameter int   V_SYNC   = XGA_V_SYNC,
    parameter int   V_BP     = XGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = VGA_CNT_W
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    localparam int LP_H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int LP_V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int LP_HS_START = H_VIS + H_FP;
    localparam int LP_VS_START = V_VIS + V_FP;

    logic        h_wrap, v_wrap;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    tg_axis_counter #(
        .CNT_W(CNT_W), .TOTAL(LP_H_TOT), .SYNC_START(LP_HS_START),
        .SYNC_END(LP_HS_START + H_SYNC), .VIS(H_VIS), .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk(pclk), .rst_n(rst_n), .en(ce),
        .count(hcount), .blank(hblnk), .sync(hsync), .wrap(h_wrap)
    );

    // The vertical axis steps only on the last pixel of a line, so its wrap
    // marks the end of the frame in the same cycle as the line wrap.
    tg_axis_counter #(
        .CNT_W(CNT_W), .TOTAL(LP_V_TOT), .SYNC_START(LP_VS_START),
        .SYNC_END(LP_VS_START + V_SYNC), .VIS(V_VIS), .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk(pclk), .rst_n(rst_n), .en(h_wrap),
        .count(vcount), .blank(vblnk), .sync(vsync), .wrap(v_wrap)
    );

    always_comb begin
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        frame_cnt_d   = frame_cnt_q;
        if (ce) begin
            line_start_d  = h_wrap;
            frame_start_d = v_wrap;
        end
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA timing generator for 1024x768 at 60 Hz: 1344 x 806 total, 65 MHz pixel clock.
- Sits directly upstream of the drawing pipeline inside arcanoid_top.
- Produces pixel coordinates, sync, blanking, line/frame strobes and a frame counter, all aligned on the same pixel.
- Every downstream stage delays its own data to match these registered outputs.

Parameters:
- H_VIS, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_VIS, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- SYNC_POL, 1'b0, active level of hsync/vsync (0 = negative, VESA)
- CNT_W, 11, width of hcount/vcount

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel enable; state advances only when high
- hcount  out  CNT_W  current pixel column, 0..H_TOT-1
- vcount  out  CNT_W  current line, 0..V_TOT-1
- hsync  out  1  horizontal sync, level SYNC_POL when active
- vsync  out  1  vertical sync, level SYNC_POL when active
- hblnk  out  1  high when hcount >= H_VIS
- vblnk  out  1  high when vcount >= V_VIS
- line_start  out  1  high for the pixel where hcount==0
- frame_start  out  1  high for the pixel where hcount==0 and vcount==0
- frame_cnt  out  16  completed-frame count, wraps 0xFFFF->0

Behaviour:
- Timing constants:
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP (1344); V_TOT likewise (806).
  - HS_START = H_VIS+H_FP (1048); HS_END = HS_START+H_SYNC (1184).
  - VS_START = V_VIS+V_FP (771); VS_END = 777.
- Reset (rst_n low, asynchronous), all outputs take these values immediately:
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=vsync=~SYNC_POL.
  - line_start=1, frame_start=1, frame_cnt=0.
- Every output is a register.
  - Derived flags are computed from the next counter values, so all outputs describe the same pixel in the same cycle. No skew between counters and flags.
- On rising pclk with ce=1:
  - hcount increments.
  - At H_TOT-1, hcount wraps to 0 and vcount increments.
  - When vcount=V_TOT-1 and hcount=H_TOT-1, both counters go to 0 and frame_cnt increments.
- ce=0: every output holds its value, including the strobes (a held strobe stays high until the next enabled cycle).
- Sync flags:
  - hsync is active for HS_START <= hcount < HS_END, on every line.
  - vsync is active for VS_START <= vcount < VS_END, across whole lines: it asserts when hcount=0 of line 771 and deasserts when hcount=0 of line 777.
- The end-of-line and end-of-frame wrap happen in the same cycle. There is no intermediate state.
- Releasing rst_n mid-frame restarts the sequence at pixel (0,0). Asserting rst_n mid-frame forces the reset values immediately.
- A parameter set whose totals do not fit in CNT_W is a compile-time error (generate-time check).

Decomposition:
- Shared package vga_pkg holds:
  - 1024x768 timing localparams: H_TOT, V_TOT, HS_START, HS_END, VS_START, VS_END.
  - A struct/bundle definition of the timing bus (hcount, vcount, hsync, vsync, hblnk, vblnk). Downstream draw stages reuse it.
- Natural sub-module: tg_axis_counter. One instance per axis, with parameters TOTAL, SYNC_START, SYNC_END, VIS.
  - Outputs count, blank, sync and wrap.
  - The vertical instance is enabled by the horizontal wrap.

Test Plan:
- Reset release, ce=1 constantly:
  - hcount reaches 1343 then 0 after exactly 1344 cycles, with vcount going 0->1.
  - The second frame_start comes 1344*806 = 1083264 cycles after the first.
- hsync check, SYNC_POL=0:
  - hsync goes low at hcount=1048 and returns high at hcount=1184.
  - hblnk rises at hcount=1024 and falls at 0.
- vsync check:
  - vsync is low exactly for lines 771..776 (6*1344 = 8064 cycles).
  - vblnk is high for lines 768..805.
  - Negedge-to-negedge vsync spacing is 1083264 cycles (16.665 ms at 65 MHz).
- ce toggled 1-of-2 cycles:
  - Counter sequence is identical to the ce=1 run, at half rate.
  - Outputs stay stable during every ce=0 cycle, including a held line_start.
- Asynchronous rst_n pulse at (hcount=500, vcount=400), asserted between clock edges:
  - Outputs go to reset values before the next edge.
  - After release, counting resumes from (0,0); frame_cnt=0.
- Run 3 frames: frame_cnt reads 3 at the fourth frame_start. Force frame_cnt=0xFFFF: it wraps to 0 at the next frame boundary.
